// File: rtl/adder_pipe.sv
// adder_pipe: segmented-carry pipelined unsigned adder/subtractor with valid/ready handshake.
// Ports: clk, rst_n (async active-low); in_valid/in_ready + a, b, sub form the operand beat;
// out_valid/out_ready + c (D_WIDTH+1 bits, MSB = carry or borrow) form the result beat;
// busy flags any valid beat held in the pipeline.
module adder_pipe #(
  parameter int D_WIDTH = 32,
  parameter int STAGES  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [D_WIDTH-1:0] a,
  input  logic [D_WIDTH-1:0] b,
  input  logic               sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D_WIDTH:0]   c,
  output logic               busy
);
  localparam int W  = (D_WIDTH + STAGES - 1) / STAGES;
  localparam int NO = (STAGES > 1) ? STAGES - 1 : 1;
  typedef logic [D_WIDTH-1:0] dw_t;
  logic              advance;
  logic [STAGES-1:0] v_q, v_d, cy_q, cy_d, sub_q, sub_d;
  dw_t               s_q[STAGES], s_d[STAGES];
  // operands travel only as far as the stage that still needs them
  dw_t               a_q[NO], a_d[NO], b_q[NO], b_d[NO];
  assign advance = !out_valid || out_ready;
  genvar k;
  for (k = 0; k < STAGES; k++) begin : g_st
    localparam int LO = (k * W < D_WIDTH) ? k * W : D_WIDTH;
    localparam int HI = ((k + 1) * W < D_WIDTH) ? (k + 1) * W : D_WIDTH;
    localparam logic [D_WIDTH:0] ONE = {{D_WIDTH{1'b0}}, 1'b1};
    localparam logic [D_WIDTH:0] M   = (ONE << HI) - (ONE << LO);
    localparam dw_t              ML  = M[D_WIDTH-1:0];
    dw_t              ai, bi, si;
    logic             ci, vi, subi;
    logic [D_WIDTH:0] t;
    if (k == 0) begin : g_in
      // subtraction is a + ~b + 1: invert b once and inject the +1 as carry-in
      assign ai   = a;
      assign bi   = sub ? ~b : b;
      assign si   = '0;
      assign ci   = sub;
      assign vi   = in_valid;
      assign subi = sub;
    end else begin : g_mid
      assign ai   = a_q[k-1];
      assign bi   = b_q[k-1];
      assign si   = s_q[k-1];
      assign ci   = cy_q[k-1];
      assign vi   = v_q[k-1];
      assign subi = sub_q[k-1];
    end
    // only the masked segment is summed; its carry lands at bit HI, the sole bit outside M
    assign t        = {1'b0, ai & ML} + {1'b0, bi & ML} + ((D_WIDTH + 1)'(ci) << LO);
    assign s_d[k]   = si | (t[D_WIDTH-1:0] & ML);
    assign cy_d[k]  = |(t & ~M);
    assign v_d[k]   = vi;
    assign sub_d[k] = subi;
    if (k < STAGES - 1) begin : g_op
      assign a_d[k] = ai;
      assign b_d[k] = bi;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v_q   <= '0;
      cy_q  <= '0;
      sub_q <= '0;
      for (int i = 0; i < STAGES; i++) s_q[i] <= '0;
      for (int i = 0; i < STAGES - 1; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else if (advance) begin
      v_q   <= v_d;
      cy_q  <= cy_d;
      sub_q <= sub_d;
      for (int i = 0; i < STAGES; i++) s_q[i] <= s_d[i];
      for (int i = 0; i < STAGES - 1; i++) begin
        a_q[i] <= a_d[i];
        b_q[i] <= b_d[i];
      end
    end
  assign in_ready  = advance;
  assign out_valid = v_q[STAGES-1];
  assign busy      = |v_q;
  // subtraction carry-out is the inverse of borrow
  assign c         = {cy_q[STAGES-1] ^ sub_q[STAGES-1], s_q[STAGES-1]};
endmodule

// File: tb/tb_adder_pipe.sv
// tb_adder_pipe: checks three adder_pipe configurations (32/2, 32/1, 8/3) against an arithmetic model.
module tb_adder_pipe;
  logic        clk = 0, rst_n = 0, in_valid = 0, sub = 0, out_ready = 1;
  logic [31:0] a = 0, b = 0;
  logic [2:0]  ov, ir, bz;
  logic [32:0] c0, c1;
  logic [8:0]  c2;
  logic [32:0] cc[3];
  logic [32:0] q[3][$];
  logic [32:0] hc[3];
  bit          hold[3];
  int          nvec = 0, nerr = 0;
  int          LAT[3] = '{2, 1, 3};
  int          WID[3] = '{32, 32, 8};
  always #5 clk = ~clk;
  assign cc[0] = c0;
  assign cc[1] = c1;
  assign cc[2] = {24'b0, c2};
  adder_pipe #(.D_WIDTH(32), .STAGES(2)) u0 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
    .a(a), .b(b), .sub(sub), .out_valid(ov[0]), .out_ready(out_ready), .c(c0), .busy(bz[0]));
  adder_pipe #(.D_WIDTH(32), .STAGES(1)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
    .a(a), .b(b), .sub(sub), .out_valid(ov[1]), .out_ready(out_ready), .c(c1), .busy(bz[1]));
  adder_pipe #(.D_WIDTH(8), .STAGES(3)) u2 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
    .a(a[7:0]), .b(b[7:0]), .sub(sub), .out_valid(ov[2]), .out_ready(out_ready), .c(c2), .busy(bz[2]));
  function automatic logic [32:0] model(logic [31:0] x, logic [31:0] y, logic s, int w);
    longint unsigned m  = (64'd1 << w) - 1;
    longint unsigned xa = x & m;
    longint unsigned ya = y & m;
    return s ? 33'(((xa < ya) ? (m + 1) : 64'd0) | ((xa - ya) & m)) : 33'(xa + ya);
  endfunction
  task automatic chk(string tag, int i, logic [32:0] obs, logic [32:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s dut%0d: got %h want %h", tag, i, obs, exp);
    end
  endtask
  task automatic tick();
    #1;
    for (int i = 0; i < 3; i++) begin
      if (hold[i]) begin
        chk("hold_c", i, cc[i], hc[i]);
        chk("hold_ov", i, 33'(ov[i]), 33'd1);
      end
      if (q[i].size() == 0) chk("idle_ov", i, 33'(ov[i]), 33'd0);
      if (ov[i] && out_ready && q[i].size() != 0) chk("result", i, cc[i], q[i].pop_front());
      hold[i] = ov[i] && !out_ready;
      hc[i]   = cc[i];
      if (in_valid && ir[i]) q[i].push_back(model(a, b, sub, WID[i]));
    end
    @(negedge clk);
  endtask
  task automatic beat(logic [31:0] x, logic [31:0] y, logic s, logic [32:0] e32, logic [32:0] e8);
    a = x; b = y; sub = s; in_valid = 1; out_ready = 1;
    tick();
    in_valid = 0;
    for (int k = 1; k <= 4; k++) begin
      for (int i = 0; i < 3; i++) begin
        chk("lat_ov", i, 33'(ov[i]), 33'(k == LAT[i]));
        if (k == LAT[i]) chk("dir_c", i, cc[i], (i == 2) ? e8 : e32);
      end
      tick();
    end
  endtask
  initial begin
    #3;
    for (int i = 0; i < 3; i++) begin
      chk("rst_ov", i, 33'(ov[i]), 33'd0);
      chk("rst_busy", i, 33'(bz[i]), 33'd0);
      chk("rst_c", i, cc[i], 33'd0);
    end
    @(negedge clk);
    rst_n = 1;
    #1;
    for (int i = 0; i < 3; i++) chk("rdy_after_rst", i, 33'(ir[i]), 33'd1);
    beat(32'd2, 32'd3, 1'b0, 33'd5, 33'd5);
    beat(32'd0, 32'd0, 1'b0, 33'd0, 33'd0);
    beat(32'hFFFF_FFFF, 32'd1, 1'b0, 33'h1_0000_0000, 33'h100);
    beat(32'd5, 32'd10, 1'b1, 33'h1_FFFF_FFFB, 33'h1FB);
    beat(32'h0000_00FF, 32'h0000_0001, 1'b0, 33'h100, 33'h100);
    for (int n = 0; n < 48; n++) begin
      a = $urandom; b = $urandom; sub = 1'($urandom);
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      tick();
    end
    in_valid = 0; out_ready = 1;
    repeat (5) tick();
    for (int i = 0; i < 3; i++) chk("drained", i, 33'(q[i].size()), 33'd0);
    in_valid = 1; out_ready = 0;
    repeat (4) begin
      a = $urandom; b = $urandom; sub = 1'($urandom);
      tick();
    end
    repeat (5) begin
      for (int i = 0; i < 3; i++) begin
        chk("stall_rdy", i, 33'(ir[i]), 33'd0);
        chk("stall_ov", i, 33'(ov[i]), 33'd1);
      end
      tick();
    end
    in_valid = 0; out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 3; i++) chk("flush_ov", i, 33'(ov[i]), 33'(k < LAT[i]));
      tick();
    end
    a = $urandom; b = $urandom; sub = 0; in_valid = 1;
    tick();
    a = $urandom; b = $urandom;
    tick();
    in_valid = 0;
    chk("busy_pre", 0, 33'(bz[0]), 33'd1);
    chk("ov_pre", 0, 33'(ov[0]), 33'd1);
    #2 rst_n = 0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("arst_ov", i, 33'(ov[i]), 33'd0);
      chk("arst_busy", i, 33'(bz[i]), 33'd0);
      chk("arst_c", i, cc[i], 33'd0);
      q[i].delete();
      hold[i] = 0;
    end
    @(negedge clk);
    rst_n = 1;
    repeat (5) tick();
    beat(32'd7, 32'd9, 1'b0, 33'd16, 33'd16);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/adder_pipe.md
ADDER_PIPE -- requirements
Module: adder_pipe

Interface
REQ-001 SHALL have parameter D_WIDTH, default 32, operand width in bits (legal 1..64).
REQ-002 SHALL have parameter STAGES, default 2, pipeline depth and number of carry-chain segments (legal 1..min(8, D_WIDTH)).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand beat valid.
REQ-006 SHALL have port in_ready  output  1  block accepts beat this cycle.
REQ-007 SHALL have port a  input  D_WIDTH  operand A, unsigned.
REQ-008 SHALL have port b  input  D_WIDTH  operand B, unsigned.
REQ-009 SHALL have port sub  input  1  0 = add, 1 = subtract; sampled with the beat.
REQ-010 SHALL have port out_valid  output  1  result beat valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 SHALL have port c  output  D_WIDTH+1  result; MSB = carry (add) or borrow (sub).
REQ-013 SHALL have port busy  output  1  high while any pipeline stage holds a valid beat.

Function
REQ-014 Transfer on input SHALL occur when in_valid && in_ready; on output, when out_valid && out_ready.
REQ-015 Pipeline SHALL advance as a whole: advance = !out_valid || out_ready; in_ready = advance.
REQ-016 Stage k (0..STAGES-1) SHALL compute segment k of the sum: segment width W = ceil(D_WIDTH/STAGES); last segment takes remainder; carry registered into stage k+1.
REQ-017 Add: c = {carry, a + b} exact over D_WIDTH+1 bits.
REQ-018 Sub: c = a + ~b + 1 over D_WIDTH bits; c[D_WIDTH] = 1 iff a < b (borrow); c[D_WIDTH-1:0] = (a - b) mod 2^D_WIDTH.
REQ-019 Latency SHALL be exactly STAGES cycles from input transfer to out_valid with no stall; throughput one beat per cycle.
REQ-020 Operand bits not yet consumed SHALL be carried forward in stage registers with their beat; results SHALL leave in acceptance order, none dropped or duplicated.
REQ-021 During stall (out_valid && !out_ready) all stage registers, c and out_valid SHALL hold; in_ready = 0.
REQ-022 Bubbles SHALL propagate as invalid stages; valid flags advance with data.
REQ-023 Simultaneous input and output transfer in a full pipeline SHALL be legal and sustain full rate.
REQ-024 c SHALL be stable while out_valid && !out_ready; value undefined-but-held when out_valid = 0.
REQ-025 busy = OR of all stage valid flags.
REQ-026 STAGES = 1 SHALL degenerate to a single registered full-width adder, latency 1.

Reset
REQ-027 rst_n low SHALL immediately (asynchronously) clear all stage valid flags; out_valid = 0, busy = 0, c = 0.
REQ-028 in_ready SHALL be 1 whenever rst_n is high and out_valid = 0, including first cycle after reset release.
REQ-029 Reset mid-operation SHALL discard all in-flight beats; none emerge after release.
REQ-030 Deassertion SHALL be synchronised externally; block state changes only on clk after release.

Verification
REQ-031 D_WIDTH=32, STAGES=2, out_ready=1: a=2,b=3,sub=0 -> c=5 with out_valid two cycles later; a=0,b=0 -> c=0.
REQ-032 Carry across segments: a=32'hFFFF_FFFF, b=1, add -> c=33'h1_0000_0000; sub a=5,b=10 -> c=33'h1_FFFF_FFFB.
REQ-033 Back-to-back 16 random beats, out_ready toggled pseudo-randomly -> results match reference model in order, c held during stall, no loss.
REQ-034 Pipeline full and out_ready=0 for 5 cycles -> in_ready=0, out_valid=1, c unchanged; then out_ready=1 -> one result per cycle.
REQ-035 rst_n pulsed low with 2 beats in flight -> out_valid=0, busy=0 immediately; no stale result after release.
REQ-036 Repeat REQ-031/032 for STAGES=1 (latency 1) and D_WIDTH=8, STAGES=3 (segments 3,3,2): 8'hFF+8'h01 -> c=9'h100.
